window_feeder: RTL and testbench

Streaming window generator feeding a `neuron_layer` input port. It accepts one fixed-point sample per handshake from a serial feature stream. It assembles sliding windows of `WINDOW` consecutive samples, advancing by `STRIDE` samples per window, and presents each window as a parallel vector on a valid/ready interface. Sequence framing is fixed at `SEQ_LEN` samples, and the final window of each frame is flagged.

---
 rtl/window_feeder.sv | 198 +++++++++++++++++++
 tb/tb_window_feeder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_feeder.sv
// window_feeder: turns a serial sample stream into sliding windows of
// WINDOW samples (advance STRIDE) framed every SEQ_LEN samples.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   feeder_valid_in   upstream sample valid
//   feeder_data_in    upstream sample
//   feeder_ready_in   block can take a sample this cycle
//   feeder_valid_out  window valid (registered)
//   feeder_data_out   window, [0] oldest .. [WINDOW-1] newest
//   feeder_last_out   current window is the last of its frame
//   feeder_ready_out  downstream accepts the window
module window_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int WINDOW     = 5,
    parameter int STRIDE     = 1,
    parameter int SEQ_LEN    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  feeder_valid_in,
    input  logic [DATA_WIDTH-1:0] feeder_data_in,
    output logic                  feeder_ready_in,
    output logic                  feeder_valid_out,
    output logic [DATA_WIDTH-1:0] feeder_data_out [0:WINDOW-1],
    output logic                  feeder_last_out,
    input  logic                  feeder_ready_out
);

    localparam int NUM_WINDOWS = (SEQ_LEN - WINDOW) / STRIDE + 1;
    localparam int DRAIN_LEN   =
        SEQ_LEN - (WINDOW + (NUM_WINDOWS - 1) * STRIDE);

    localparam int FILL_W  = $clog2(WINDOW + 1);
    localparam int SKIP_W  = $clog2(STRIDE + 1);
    localparam int WIN_W   = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
    localparam int DRAIN_W = (DRAIN_LEN > 0) ? $clog2(DRAIN_LEN + 1) : 1;

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WINDOW - 1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WINDOW);
    localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1);
    localparam logic [SKIP_W-1:0]  SKIP_FULL  = SKIP_W'(STRIDE);
    localparam logic [SKIP_W-1:0]  SKIP_PART  = SKIP_W'(STRIDE - 1);
    localparam logic [SKIP_W-1:0]  SKIP_ONE   = SKIP_W'(1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(NUM_WINDOWS - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_FULL = DRAIN_W'(DRAIN_LEN);
    localparam logic [DRAIN_W-1:0] DRAIN_PART =
        DRAIN_W'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    typedef enum logic [1:0] {
        S_FILL,
        S_HOLD,
        S_SKIP,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic                  r_valid;
    logic [FILL_W-1:0]     r_fill_cnt;
    logic [SKIP_W-1:0]     r_skip_cnt;
    logic [WIN_W-1:0]      r_win_cnt;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic [DATA_WIDTH-1:0] r_shift [0:WINDOW-1];

    logic w_accept;
    logic w_handshake;
    logic w_win_last;

    // While a window waits, a new sample may only enter in the same
    // cycle the window leaves, otherwise the window would be overwritten.
    assign feeder_ready_in =
        ~rst & ((r_state != S_HOLD) | feeder_ready_out);

    assign w_accept    = feeder_valid_in & feeder_ready_in;
    assign w_handshake = r_valid & feeder_ready_out;
    assign w_win_last  = (r_win_cnt == WIN_LAST);

    assign feeder_valid_out = r_valid;
    assign feeder_last_out  = r_valid & w_win_last;
    assign feeder_data_out  = r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                r_shift[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < WINDOW - 1; i++) begin
                r_shift[i] <= r_shift[i+1];
            end
            r_shift[WINDOW-1] <= feeder_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_valid     <= 1'b0;
            r_fill_cnt  <= '0;
            r_skip_cnt  <= '0;
            r_win_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (r_fill_cnt == FILL_LAST) begin
                            r_fill_cnt <= FILL_FULL;
                            r_state    <= S_HOLD;
                            r_valid    <= 1'b1;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + FILL_ONE;
                        end
                    end
                end

                S_HOLD: begin
                    if (w_handshake) begin
                        if (!w_win_last) begin
                            r_win_cnt <= r_win_cnt + WIN_ONE;
                            if (w_accept) begin
                                // With STRIDE 1 the accepted sample
                                // already completes the next window.
                                if (STRIDE != 1) begin
                                    r_state    <= S_SKIP;
                                    r_skip_cnt <= SKIP_PART;
                                    r_valid    <= 1'b0;
                                end
                            end else begin
                                r_state    <= S_SKIP;
                                r_skip_cnt <= SKIP_FULL;
                                r_valid    <= 1'b0;
                            end
                        end else begin
                            r_win_cnt  <= '0;
                            r_fill_cnt <= '0;
                            r_valid    <= 1'b0;
                            if (DRAIN_LEN > 0) begin
                                // A coincident sample is the first
                                // sample of the drain tail.
                                if (w_accept && DRAIN_LEN == 1) begin
                                    r_state     <= S_FILL;
                                    r_drain_cnt <= '0;
                                end else begin
                                    r_state     <= S_DRAIN;
                                    r_drain_cnt <= w_accept ? DRAIN_PART
                                                            : DRAIN_FULL;
                                end
                            end else begin
                                // No tail: a coincident sample opens
                                // the next frame.
                                r_state <= S_FILL;
                                if (w_accept) begin
                                    r_fill_cnt <= FILL_ONE;
                                    if (WINDOW == 1) begin
                                        r_state <= S_HOLD;
                                        r_valid <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end

                S_SKIP: begin
                    if (w_accept) begin
                        if (r_skip_cnt == SKIP_ONE) begin
                            r_skip_cnt <= '0;
                            r_state    <= S_HOLD;
                            r_valid    <= 1'b1;
                        end else begin
                            r_skip_cnt <= r_skip_cnt - SKIP_ONE;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_accept) begin
                        if (r_drain_cnt == DRAIN_ONE) begin
                            r_drain_cnt <= '0;
                            r_state     <= S_FILL;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - DRAIN_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= S_FILL;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Testbench for window_feeder: table vectors, hand sequences for framing,
// backpressure, bubbles and reset, plus randomized traffic vs a model.
module tb_window_feeder;

    localparam int W = 5;
    typedef logic [31:0] win_t [0:W-1];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: STRIDE 1, SEQ_LEN 8. DUT B: STRIDE 2, SEQ_LEN 10.
    logic        a_rst, a_vin, a_rout, a_ri, a_vo, a_lo;
    logic [31:0] a_din;
    win_t        a_dout;
    logic        b_rst, b_vin, b_rout, b_ri, b_vo, b_lo;
    logic [31:0] b_din;
    win_t        b_dout;

    window_feeder #(.DATA_WIDTH(32), .WINDOW(W), .STRIDE(1), .SEQ_LEN(8)) u_a (
        .clk(clk), .rst(a_rst),
        .feeder_valid_in(a_vin), .feeder_data_in(a_din),
        .feeder_ready_in(a_ri), .feeder_valid_out(a_vo),
        .feeder_data_out(a_dout), .feeder_last_out(a_lo),
        .feeder_ready_out(a_rout)
    );

    window_feeder #(.DATA_WIDTH(32), .WINDOW(W), .STRIDE(2), .SEQ_LEN(10)) u_b (
        .clk(clk), .rst(b_rst),
        .feeder_valid_in(b_vin), .feeder_data_in(b_din),
        .feeder_ready_in(b_ri), .feeder_valid_out(b_vo),
        .feeder_data_out(b_dout), .feeder_last_out(b_lo),
        .feeder_ready_out(b_rout)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: frame position, windows taken, frame history.
    int          cfg_s [2];
    int          cfg_l [2];
    bit          m_en [2];
    int          m_pos [2];
    int          m_nwin [2];
    logic [31:0] m_frame [2][16];
    logic [31:0] m_sh [2][W];
    bit          m_acc [2];
    bit          m_hs [2];
    bit          m_rst [2];
    logic [31:0] m_din [2];

    int q_base [$];
    bit q_last [$];

    function automatic logic [31:0] b32(input logic x);
        return {31'b0, x};
    endfunction

    task automatic cmp(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
                     nm, id, act, exp, $time);
        end
    endtask

    function automatic int nw(input int id);
        return (cfg_l[id] - W) / cfg_s[id] + 1;
    endfunction

    function automatic bit m_valid(input int id);
        return (m_nwin[id] < nw(id)) &&
               (m_pos[id] == m_nwin[id] * cfg_s[id] + W);
    endfunction

    task automatic chk(input int id, input logic rst, input logic vin,
                       input logic rout, input logic [31:0] din,
                       input logic vo, input logic lo, input logic ri,
                       input win_t d);
        bit ev, er, el;
        if (!m_en[id]) begin
            m_rst[id] = rst;
            m_acc[id] = 1'b0;
            m_hs[id]  = 1'b0;
            return;
        end
        ev = m_valid(id);
        er = !rst && (!ev || rout);
        el = ev && (m_nwin[id] == nw(id) - 1);
        cmp("valid_out", id, b32(vo), b32(ev));
        cmp("ready_in", id, b32(ri), b32(er));
        cmp("last_out", id, b32(lo), b32(el));
        for (int k = 0; k < W; k++) begin
            cmp($sformatf("data_out[%0d]", k), id, d[k], m_sh[id][k]);
        end
        if (ev) begin
            for (int k = 0; k < W; k++) begin
                cmp($sformatf("window[%0d]", k), id, d[k],
                    m_frame[id][m_nwin[id] * cfg_s[id] + k]);
            end
        end
        m_acc[id] = vin && er;
        m_hs[id]  = ev && rout;
        m_din[id] = din;
        m_rst[id] = rst;
    endtask

    task automatic upd(input int id);
        if (m_rst[id]) begin
            m_en[id]   = 1'b1;
            m_pos[id]  = 0;
            m_nwin[id] = 0;
            for (int k = 0; k < W; k++) m_sh[id][k] = '0;
            return;
        end
        if (!m_en[id]) return;
        if (m_acc[id]) begin
            for (int k = 0; k < W - 1; k++) m_sh[id][k] = m_sh[id][k+1];
            m_sh[id][W-1] = m_din[id];
            m_frame[id][m_pos[id]] = m_din[id];
            m_pos[id]++;
        end
        if (m_hs[id]) m_nwin[id]++;
        if (m_nwin[id] == nw(id) && m_pos[id] >= cfg_l[id]) begin
            if (m_pos[id] > cfg_l[id])
                m_frame[id][0] = m_frame[id][cfg_l[id]];
            m_pos[id]  = m_pos[id] - cfg_l[id];
            m_nwin[id] = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        chk(0, a_rst, a_vin, a_rout, a_din, a_vo, a_lo, a_ri, a_dout);
        chk(1, b_rst, b_vin, b_rout, b_din, b_vo, b_lo, b_ri, b_dout);
        @(posedge clk);
        upd(0);
        upd(1);
        @(negedge clk);
    endtask

    task automatic rec(input int id);
        logic vo, lo;
        win_t d;
        if (id == 0) begin
            vo = a_vo; lo = a_lo; d = a_dout;
        end else begin
            vo = b_vo; lo = b_lo; d = b_dout;
        end
        if (vo === 1'b1) begin
            q_base.push_back(int'(d[0]));
            q_last.push_back(lo);
            for (int k = 1; k < W; k++) begin
                cmp("window_order", id, d[k], d[0] + 32'(k));
            end
        end
    endtask

    task automatic drive(input int id, input logic vin,
                         input logic [31:0] din, input logic rout);
        if (id == 0) begin
            a_vin = vin; a_din = din; a_rout = rout;
        end else begin
            b_vin = vin; b_din = din; b_rout = rout;
        end
    endtask

    task automatic feed(input int id, input int first, input int n);
        int cnt = 0;
        int cyc = 0;
        bit acc;
        while (cnt < n && cyc < 100) begin
            drive(id, 1'b1, 32'(first + cnt), 1'b1);
            #1;
            rec(id);
            acc = (id == 0) ? (a_vin && a_ri) : (b_vin && b_ri);
            tick();
            if (acc) cnt++;
            cyc++;
        end
        cmp("feed_samples_taken", id, 32'(cnt), 32'(n));
        drive(id, 1'b0, '0, 1'b1);
        repeat (3) begin
            #1;
            rec(id);
            tick();
        end
    endtask

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        rout;
        logic        ev;
        logic        el;
        logic        er;
        logic [31:0] d0;
        logic [31:0] d4;
    } vec_t;

    vec_t tv [25];

    function automatic vec_t mk(input logic vin, input int din,
                                input logic rout, input logic ev,
                                input logic el, input logic er,
                                input int d0, input int d4);
        vec_t v;
        v.vin = vin; v.din = 32'(din); v.rout = rout;
        v.ev = ev; v.el = el; v.er = er;
        v.d0 = 32'(d0); v.d4 = 32'(d4);
        return v;
    endfunction

    initial begin
        int first_v;
        int acc_n;
        int eb [4];
        bit el [4];

        // inputs: vin din rout | expected: valid last ready d0 d4
        tv[0]  = mk(1, 1, 1,  0, 0, 1,  0, 0);
        tv[1]  = mk(1, 2, 1,  0, 0, 1,  0, 1);
        tv[2]  = mk(1, 3, 1,  0, 0, 1,  0, 2);
        tv[3]  = mk(1, 4, 1,  0, 0, 1,  0, 3);
        tv[4]  = mk(1, 5, 1,  0, 0, 1,  0, 4);
        tv[5]  = mk(1, 6, 1,  1, 0, 1,  1, 5);
        tv[6]  = mk(1, 7, 1,  1, 0, 1,  2, 6);
        tv[7]  = mk(1, 8, 1,  1, 0, 1,  3, 7);
        tv[8]  = mk(1, 9, 1,  1, 1, 1,  4, 8);
        tv[9]  = mk(1, 10, 1, 0, 0, 1,  5, 9);
        tv[10] = mk(1, 11, 1, 0, 0, 1,  6, 10);
        tv[11] = mk(1, 12, 1, 0, 0, 1,  7, 11);
        tv[12] = mk(1, 13, 1, 0, 0, 1,  8, 12);
        tv[13] = mk(0, 0, 0,  1, 0, 0,  9, 13);
        tv[14] = mk(1, 99, 0, 1, 0, 0,  9, 13);
        tv[15] = mk(1, 99, 0, 1, 0, 0,  9, 13);
        tv[16] = mk(1, 14, 1, 1, 0, 1,  9, 13);
        tv[17] = mk(0, 0, 1,  1, 0, 1,  10, 14);
        tv[18] = mk(1, 15, 1, 0, 0, 1,  10, 14);
        tv[19] = mk(0, 0, 1,  1, 0, 1,  11, 15);
        tv[20] = mk(0, 0, 1,  0, 0, 1,  11, 15);
        tv[21] = mk(1, 16, 0, 0, 0, 1,  11, 15);
        tv[22] = mk(0, 0, 0,  1, 1, 0,  12, 16);
        tv[23] = mk(0, 0, 1,  1, 1, 1,  12, 16);
        tv[24] = mk(0, 0, 1,  0, 0, 1,  12, 16);

        cfg_s = '{1, 2};
        cfg_l = '{8, 10};
        m_en  = '{0, 0};
        a_rst = 1'b1; a_vin = 1'b0; a_din = '0; a_rout = 1'b1;
        b_rst = 1'b1; b_vin = 1'b0; b_din = '0; b_rout = 1'b1;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Table: full frame, back-to-back frame, backpressure, skip.
        for (int i = 0; i < 25; i++) begin
            drive(0, tv[i].vin, tv[i].din, tv[i].rout);
            #1;
            cmp($sformatf("tab%0d_valid", i), 0, b32(a_vo), b32(tv[i].ev));
            cmp($sformatf("tab%0d_last", i), 0, b32(a_lo), b32(tv[i].el));
            cmp($sformatf("tab%0d_ready", i), 0, b32(a_ri), b32(tv[i].er));
            cmp($sformatf("tab%0d_d0", i), 0, a_dout[0], tv[i].d0);
            cmp($sformatf("tab%0d_d4", i), 0, a_dout[W-1], tv[i].d4);
            tick();
        end

        // STRIDE 2 frame with one drained sample, then the next frame.
        q_base.delete();
        q_last.delete();
        feed(1, 1, 15);
        eb = '{1, 3, 5, 11};
        el = '{0, 0, 1, 0};
        cmp("b_window_count", 1, 32'(q_base.size()), 32'd4);
        for (int i = 0; i < 4 && i < q_base.size(); i++) begin
            cmp($sformatf("b_win%0d_base", i), 1, 32'(q_base[i]), 32'(eb[i]));
            cmp($sformatf("b_win%0d_last", i), 1, b32(q_last[i]), b32(el[i]));
        end

        // Upstream bubbles during fill, window then held.
        first_v = -1;
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, (i < 10) && (i % 2 == 0), 32'(101 + acc_n), 1'b0);
            #1;
            if (a_vo === 1'b1 && first_v < 0) first_v = i;
            if (a_vin && a_ri) acc_n++;
            tick();
        end
        cmp("bubble_first_valid", 0, 32'(first_v), 32'd9);
        for (int k = 0; k < W; k++) begin
            cmp($sformatf("bubble_win[%0d]", k), 0, a_dout[k], 32'(101 + k));
        end

        // Reset in the middle of a frame.
        a_rst = 1'b1;
        drive(0, 1'b0, '0, 1'b1);
        tick();
        a_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 32'(50 + i), 1'b1);
            tick();
        end
        a_rst = 1'b1;
        drive(0, 1'b0, '0, 1'b1);
        #1;
        cmp("rst_ready_in", 0, b32(a_ri), 32'd0);
        tick();
        cmp("rst_valid", 0, b32(a_vo), 32'd0);
        cmp("rst_last", 0, b32(a_lo), 32'd0);
        for (int k = 0; k < W; k++) begin
            cmp($sformatf("rst_data[%0d]", k), 0, a_dout[k], 32'd0);
        end
        a_rst = 1'b0;
        #1;
        cmp("post_rst_ready_in", 0, b32(a_ri), 32'd1);
        q_base.delete();
        q_last.delete();
        feed(0, 20, 8);
        eb = '{20, 21, 22, 23};
        el = '{0, 0, 0, 1};
        cmp("a_window_count", 0, 32'(q_base.size()), 32'd4);
        for (int i = 0; i < 4 && i < q_base.size(); i++) begin
            cmp($sformatf("a_win%0d_base", i), 0, 32'(q_base[i]), 32'(eb[i]));
            cmp($sformatf("a_win%0d_last", i), 0, b32(q_last[i]), b32(el[i]));
        end

        // Randomized traffic on both instances against the model.
        repeat (3000) begin
            a_vin  = ($urandom_range(0, 3) != 0);
            a_rout = ($urandom_range(0, 2) != 0);
            a_din  = $urandom;
            a_rst  = ($urandom_range(0, 299) == 0);
            b_vin  = ($urandom_range(0, 2) != 0);
            b_rout = ($urandom_range(0, 3) != 0);
            b_din  = $urandom;
            b_rst  = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
